pipeline_stitch_rv: RTL and testbench
=====================================

# pipeline_stitch_rv

Parametrised stitched pipeline wrapper with a full ready/valid handshake. It has one input capture register and NUM_STAGES registered stages. Each stage adds a constant INCR modulo 2^DATA_WIDTH. Per-slot valid bits collapse bubbles, output backpressure propagates to the input, and a synchronous flush empties the pipe. It replaces fixed-depth, valid-only stitched pipelines wherever a downstream consumer can stall.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits (≥1).
- NUM_STAGES, 2, number of compute stages after the input capture slot (1..16).
- INCR, 1, per-stage addend; truncated to DATA_WIDTH bits.

Ports (OCC_W = $clog2(NUM_STAGES+2)):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset. Asserting it clears all state immediately. Deassertion is synchronous to clk (externally synchronised).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_WIDTH  input payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_WIDTH  result payload.
- flush  in  1  synchronous discard of all in-flight items.
- occupancy  out  OCC_W  number of valid slots (0..NUM_STAGES+1).

## Operation
- Storage: slots 0..NUM_STAGES, each a data register d[k] plus a valid bit v[k]. The pipeline holds NUM_STAGES+1 items maximum.
- Slot 0 captures raw in_data.
- Slot k (k≥1) captures d[k-1] + INCR, computed modulo 2^DATA_WIDTH.
- out_data = d[NUM_STAGES]; out_valid = v[NUM_STAGES].
- Result: out_data = in_data + NUM_STAGES·INCR, mod 2^DATA_WIDTH.
- Ready chain (combinational):
  - rdy[NUM_STAGES] = ~v[NUM_STAGES] | out_ready.
  - rdy[k] = ~v[k] | rdy[k+1].
  - in_ready = rdy[0] & ~flush.
- Per-slot update when not flushing:
  - If rdy[k]: v[k] ← upstream valid, where upstream is in_valid for k=0 and v[k-1] otherwise.
  - If rdy[k] and upstream valid: d[k] loads.
  - Otherwise d[k] and v[k] hold.
  - Data registers never load from an invalid source.
- Bubble collapse: an empty slot accepts even while downstream is stalled. Items compact toward the output under stall.
- Flush: when flush=1 at a rising edge, every v[k] ← 0.
  - d[k] holds its value.
  - No input is accepted that cycle.
  - out_valid may be 1 in the flush cycle. A transfer (out_valid & out_ready) that cycle still counts as delivered.
- occupancy = popcount(v[0..NUM_STAGES]), registered-state derived (combinational from v).
- Reset (rst_n=0), asynchronous:
  - All v[k]=0 and all d[k]=0.
  - Outputs: out_valid=0, out_data=0, occupancy=0.
  - in_ready=1 whenever flush=0.

## Timing
- Transfer occurs on a rising edge when valid & ready are both high at that edge. This applies on both sides.
- Latency: an item accepted at edge T appears with out_valid=1 after edge T+NUM_STAGES (NUM_STAGES+1 register slots, first slot loaded at T). This holds when out_ready stays 1.
- Throughput: one item per cycle when out_ready=1 continuously.
- in_ready is combinational from out_ready (ready chain); there are no registered-ready bubbles.
- Full pipe with out_ready=0: in_ready=0 and occupancy=NUM_STAGES+1.
- Full pipe, out_ready=1: in_ready=1 in the same cycle, so output and input transfer simultaneously.
- Stall: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Wrap-around: the addition wraps silently. There is no carry or overflow flag.
- Reset mid-operation: all in-flight items are lost. The first post-reset edge accepts a new input if in_valid=1.
- flush with in_valid=1 in the same cycle: the input is not accepted (in_ready=0), and upstream must hold.

## Test plan
- Streaming, defaults, out_ready=1: send x=0,1,0xFFFFFFFE on consecutive edges. Expect out_data=2,3,0x00000000 (wrap) on consecutive cycles. First out_valid follows the edge 2 cycles after the first acceptance.
- Backpressure fill: out_ready=0, in_valid=1 for 5 cycles with NUM_STAGES=2. Expect 3 accepts, then in_ready=0 and occupancy=3. Then out_ready=1 drains in order with no loss or duplication.
- Bubble collapse: send an item, idle one cycle, send a second with out_ready=0. Expect occupancy=2 with both items compacted into slots 2 and 1 after 3 edges.
- Flush: with occupancy=3, pulse flush with in_valid=1. Expect in_ready=0 in that cycle and occupancy=0 and out_valid=0 next cycle. The pulsed input is not consumed.
- Async reset: assert rst_n=0 mid-stream between edges. Expect out_valid=0, out_data=0 and occupancy=0 immediately, with no clock edge.
- Parameter sweep: DATA_WIDTH=8, NUM_STAGES=5, INCR=0x33, x=0x10. Expect out_data=0x0F (0x10+0xFF mod 256) with 6-cycle latency. Also run a random stall/flush scoreboard.

Source files
------------

// File: rtl/pipeline_stitch_rv_if.sv
// Valid/ready stream bundle; master drives valid/data, slave drives ready.
interface pipeline_stitch_rv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_stitch_rv.sv
// Stitched add-constant pipeline: capture slot + NUM_STAGES stages, each adding INCR.
// Latency: NUM_STAGES+1 edges from accept to out_valid when unstalled; 1 item/cycle.
// Backpressure: combinational ready chain, empty slots fill under stall; flush drops all.
module pipeline_stitch_rv #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_STAGES = 2,
    parameter logic [63:0] INCR       = 64'd1,
    parameter int          OCC_W      = $clog2(NUM_STAGES + 2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pipeline_stitch_rv_if.slave        i_in,
    pipeline_stitch_rv_if.master       o_out,
    input  logic                       i_flush,
    output logic [OCC_W-1:0]           o_occupancy
);
    localparam logic [DATA_WIDTH-1:0] INCR_W = DATA_WIDTH'(INCR);

    logic [DATA_WIDTH-1:0] r_dat [NUM_STAGES+1];
    logic [NUM_STAGES:0]   r_vld;

    logic [DATA_WIDTH-1:0] w_nxt_dat [NUM_STAGES+1];
    logic [NUM_STAGES:0]   w_up_vld;
    logic [NUM_STAGES:0]   w_rdy;
    logic [OCC_W-1:0]      w_occ;

    // Slot k is ready unless it and every slot downstream are full and the
    // output is stalled; evaluated flat so the chain has no self-referencing vector.
    function automatic logic slot_rdy(input logic [NUM_STAGES:0] v, input int k,
                                      input logic ordy);
        logic full;
        full = 1'b1;
        for (int j = 0; j <= NUM_STAGES; j++) begin
            if (j >= k) begin
                full = full & v[j];
            end
        end
        return ~full | ordy;
    endfunction

    for (genvar k = 0; k <= NUM_STAGES; k++) begin : g_slot
        assign w_rdy[k] = slot_rdy(r_vld, k, o_out.ready);
        if (k == 0) begin : g_cap
            assign w_up_vld[k]  = i_in.valid;
            assign w_nxt_dat[k] = i_in.data;
        end else begin : g_stage
            assign w_up_vld[k]  = r_vld[k-1];
            assign w_nxt_dat[k] = r_dat[k-1] + INCR_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k <= NUM_STAGES; k++) begin
                r_dat[k] <= '0;
            end
        end else if (i_flush) begin
            // Data registers keep their contents; only the valid bits drop.
            r_vld <= '0;
        end else begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_up_vld[k];
                    if (w_up_vld[k]) begin
                        r_dat[k] <= w_nxt_dat[k];
                    end
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k <= NUM_STAGES; k++) begin
            w_occ = w_occ + OCC_W'(r_vld[k]);
        end
    end

    assign i_in.ready  = w_rdy[0] & ~i_flush;
    assign o_out.valid = r_vld[NUM_STAGES];
    assign o_out.data  = r_dat[NUM_STAGES];
    assign o_occupancy = w_occ;
endmodule

// File: tb/tb_pipeline_stitch_rv.sv
// Bench for pipeline_stitch_rv: default instance (32b, 2 stages, +1) and sweep instance (8b, 5 stages, +0x33).
module tb_pipeline_stitch_rv;
    logic clk;
    logic rst_n;

    logic        a_ivld, a_ordy, a_fl;
    logic [31:0] a_idat;
    logic        b_ivld, b_ordy, b_fl;
    logic [7:0]  b_idat;
    logic [1:0]  occ_a;
    logic [2:0]  occ_b;

    int n_pass = 0;
    int n_tot  = 0;

    // Item-level model: per DUT, items oldest-first with their slot position.
    logic [31:0] mv [2][8];
    int          mp [2][8];
    int          mn [2];

    pipeline_stitch_rv_if #(.DATA_WIDTH(32)) ai ();
    pipeline_stitch_rv_if #(.DATA_WIDTH(32)) ao ();
    pipeline_stitch_rv_if #(.DATA_WIDTH(8))  bi ();
    pipeline_stitch_rv_if #(.DATA_WIDTH(8))  bo ();

    assign ai.valid = a_ivld;
    assign ai.data  = a_idat;
    assign ao.ready = a_ordy;
    assign bi.valid = b_ivld;
    assign bi.data  = b_idat;
    assign bo.ready = b_ordy;

    pipeline_stitch_rv #(.DATA_WIDTH(32), .NUM_STAGES(2), .INCR(64'd1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_in(ai), .o_out(ao),
        .i_flush(a_fl), .o_occupancy(occ_a));

    pipeline_stitch_rv #(.DATA_WIDTH(8), .NUM_STAGES(5), .INCR(64'h33)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_in(bi), .o_out(bo),
        .i_flush(b_fl), .o_occupancy(occ_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_cycle(input int d, input logic ovld, input logic [63:0] odat,
                               input logic [63:0] oocc, input logic irdy, input logic ordy,
                               input logic fl, input logic ivld, input logic [31:0] idat);
        int          nst, lim, k;
        logic [31:0] incr, mask;
        int          np [8];
        bit          lv, s0free, ev;
        string       pfx;
        nst  = (d == 0) ? 2 : 5;
        incr = (d == 0) ? 32'd1 : 32'h33;
        mask = (d == 0) ? 32'hFFFF_FFFF : 32'hFF;
        pfx  = (d == 0) ? "a" : "b";
        lv   = 1'b0;
        lim  = nst;
        // Each item advances one slot unless blocked by the item ahead of it.
        for (int i = 0; i < mn[d]; i++) begin
            if (i == 0 && mp[d][0] == nst && ordy) begin
                lv = 1'b1;
                np[i] = nst + 1;
                lim = nst;
            end else begin
                np[i] = (mp[d][i] + 1 < lim) ? mp[d][i] + 1 : lim;
                lim = np[i] - 1;
            end
        end
        s0free = (lim >= 0);
        ev = (mn[d] > 0) && (mp[d][0] == nst);
        check({pfx, "_out_valid"}, 64'(ovld), 64'(ev));
        if (ev) check({pfx, "_out_data"}, odat, 64'(mv[d][0]));
        check({pfx, "_occupancy"}, oocc, 64'(mn[d]));
        check({pfx, "_in_ready"}, 64'(irdy), 64'(~fl & s0free));
        if (fl) begin
            mn[d] = 0;
        end else begin
            k = 0;
            for (int i = 0; i < mn[d]; i++) begin
                if (!(lv && i == 0)) begin
                    mv[d][k] = mv[d][i];
                    mp[d][k] = np[i];
                    k++;
                end
            end
            mn[d] = k;
            if (ivld && s0free) begin
                mv[d][mn[d]] = (idat + nst * incr) & mask;
                mp[d][mn[d]] = 0;
                mn[d]++;
            end
        end
    endtask

    task automatic step();
        #1;
        model_cycle(0, ao.valid, 64'(ao.data), 64'(occ_a), ai.ready, a_ordy, a_fl, a_ivld, a_idat);
        model_cycle(1, bo.valid, 64'(bo.data), 64'(occ_b), bi.ready, b_ordy, b_fl, b_ivld, 32'(b_idat));
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [31:0] dat, input logic r, input logic f);
        a_ivld = v; a_idat = dat; a_ordy = r; a_fl = f;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] dat, input logic r, input logic f);
        b_ivld = v; b_idat = dat; b_ordy = r; b_fl = f;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_valid"}, 64'(ao.valid), 64'd0);
        check({tag, "_a_data"},  64'(ao.data),  64'd0);
        check({tag, "_a_occ"},   64'(occ_a),    64'd0);
        check({tag, "_a_ready"}, 64'(ai.ready), 64'd1);
        check({tag, "_b_valid"}, 64'(bo.valid), 64'd0);
        check({tag, "_b_data"},  64'(bo.data),  64'd0);
        check({tag, "_b_occ"},   64'(occ_b),    64'd0);
    endtask

    initial begin
        mn[0] = 0;
        mn[1] = 0;
        rst_n = 1'b0;
        drive_a(1'b0, 32'd0, 1'b1, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b0);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with wrap: 0, 1, 0xFFFFFFFE -> 2, 3, 0.
        drive_a(1'b1, 32'd0, 1'b1, 1'b0);          step();
        drive_a(1'b1, 32'd1, 1'b1, 1'b0);          step();
        check("stream_lat_not_yet", 64'(ao.valid), 64'd0);
        drive_a(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);  step();
        check("stream_v0", 64'(ao.valid), 64'd1);
        check("stream_d0", 64'(ao.data), 64'd2);
        drive_a(1'b0, 32'd0, 1'b1, 1'b0);          step();
        check("stream_d1", 64'(ao.data), 64'd3);
        step();
        check("stream_v2", 64'(ao.valid), 64'd1);
        check("stream_d2_wrap", 64'(ao.data), 64'd0);
        step();
        check("stream_drained", 64'(ao.valid), 64'd0);

        // Backpressure fill: only three items fit.
        drive_a(1'b1, 32'd10, 1'b0, 1'b0); step();
        drive_a(1'b1, 32'd11, 1'b0, 1'b0); step();
        drive_a(1'b1, 32'd12, 1'b0, 1'b0); step();
        drive_a(1'b1, 32'd13, 1'b0, 1'b0); step();
        step();
        check("fill_occ", 64'(occ_a), 64'd3);
        check("fill_in_ready", 64'(ai.ready), 64'd0);
        drive_a(1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        check("full_passthru_ready", 64'(ai.ready), 64'd1);
        check("drain_d0", 64'(ao.data), 64'd12);
        step();
        check("drain_d1", 64'(ao.data), 64'd13);
        step();
        check("drain_d2", 64'(ao.data), 64'd14);
        step();
        check("drain_empty", 64'(ao.valid), 64'd0);

        // Bubble collapse under stall.
        drive_a(1'b1, 32'd20, 1'b0, 1'b0); step();
        drive_a(1'b0, 32'd0,  1'b0, 1'b0); step();
        drive_a(1'b1, 32'd21, 1'b0, 1'b0); step();
        check("bubble_occ", 64'(occ_a), 64'd2);
        drive_a(1'b0, 32'd0, 1'b0, 1'b0);  step();
        check("bubble_occ_compact", 64'(occ_a), 64'd2);
        check("bubble_head", 64'(ao.data), 64'd22);
        check("bubble_slot0_free", 64'(ai.ready), 64'd1);
        drive_a(1'b0, 32'd0, 1'b1, 1'b0);  step();
        check("bubble_second", 64'(ao.data), 64'd23);
        step(); step();

        // Flush with a pending input.
        drive_a(1'b1, 32'd30, 1'b0, 1'b0); step();
        drive_a(1'b1, 32'd31, 1'b0, 1'b0); step();
        drive_a(1'b1, 32'd32, 1'b0, 1'b0); step();
        check("flush_pre_occ", 64'(occ_a), 64'd3);
        drive_a(1'b1, 32'd99, 1'b0, 1'b1);
        #1;
        check("flush_in_ready", 64'(ai.ready), 64'd0);
        step();
        drive_a(1'b0, 32'd0, 1'b1, 1'b0);
        check("flush_occ", 64'(occ_a), 64'd0);
        check("flush_valid", 64'(ao.valid), 64'd0);
        step();

        // Parameter sweep instance: 0x10 + 5*0x33 = 0x10F -> 0x0F.
        drive_b(8'h1 != 0, 8'h10, 1'b1, 1'b0); step();
        drive_b(1'b0, 8'h00, 1'b1, 1'b0);
        step(); step(); step(); step();
        check("sweep_not_yet", 64'(bo.valid), 64'd0);
        step();
        check("sweep_valid", 64'(bo.valid), 64'd1);
        check("sweep_data", 64'(bo.data), 64'h0F);
        step();

        // Asynchronous reset between edges.
        drive_a(1'b1, 32'h55, 1'b1, 1'b0); step();
        drive_a(1'b1, 32'h56, 1'b1, 1'b0); step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mn[0] = 0;
        mn[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1'b1, 32'h77, 1'b1, 1'b0); step();
        drive_a(1'b0, 32'd0, 1'b1, 1'b0);  step();
        step();
        check("post_rst_data", 64'(ao.data), 64'h79);
        step();

        // Random stall/flush traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            drive_a($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 19) == 0);
            drive_b($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 6,
                    $urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
